// File: rtl/arith_pkg.sv
// Arithmetic library package: divider FSM states and sizing helpers.
// Shared by divider_seq, its interface and its step logic.
package arith_pkg;

    localparam int DIV_W_DEFAULT = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // Width of a counter that has to hold 2W-1 down to 0.
    function automatic int cnt_width(input int w);
        return (2 * w > 1) ? $clog2(2 * w) : 1;
    endfunction

    localparam int DIV_CNT_W_DEFAULT = cnt_width(DIV_W_DEFAULT);

endpackage

// File: rtl/divider_seq_if.sv
// Request/result bundle of the sequential divider.
// master: start, in1, in2 out; slave: busy, done, q, r, div_by_zero out.
interface divider_seq_if
    import arith_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
);
    logic             start;
    logic [2*W-1:0]   in1;
    logic [W-1:0]     in2;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   q;
    logic [W-1:0]     r;
    logic             div_by_zero;

    modport master (
        output start, in1, in2,
        input  busy, done, q, r, div_by_zero
    );

    modport slave (
        input  start, in1, in2,
        output busy, done, q, r, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift a dividend bit into the remainder,
// subtract the divisor if it fits. Ports: rem, dbit, divisor in;
// rem_next, q_bit out. Purely combinational.
module div_step #(
    parameter int W = 2
) (
    input  logic [W-1:0] rem,
    input  logic         dbit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0] t;

    always_comb begin
        t     = {rem, dbit};
        q_bit = (t >= {1'b0, divisor});
        // After a subtraction the result is below the divisor, so the
        // top bit of the W+1-bit difference is always zero.
        rem_next = q_bit ? W'(t - {1'b0, divisor}) : t[W-1:0];
    end
endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock. Ports: clk, rst, bus (divider_seq_if.slave).
module divider_seq
    import arith_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    divider_seq_if.slave  bus
);
    localparam int CW = cnt_width(W);

    div_state_t      state;
    logic [2*W-1:0]  dvd;
    logic [W-1:0]    dvs;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  q_reg;
    logic [W-1:0]    r_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            dbz_reg;
    logic [W-1:0]    rem_next;
    logic            q_bit;

    // The remainder register doubles as the working remainder; it always
    // stays below the divisor, so W bits hold it between steps.
    div_step #(.W(W)) u_step (
        .rem      (r_reg),
        .dbit     (dvd[2*W-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            dvd      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        dvd      <= bus.in1;
                        dvs      <= bus.in2;
                        cnt      <= CW'(2 * W - 1);
                        r_reg    <= '0;
                        busy_reg <= 1'b1;
                        if (bus.in2 == '0) begin
                            state    <= S_DONE;
                            done_reg <= 1'b1;
                            dbz_reg  <= 1'b1;
                            q_reg    <= '1;
                        end else begin
                            state    <= S_CALC;
                            dbz_reg  <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_reg <= rem_next;
                    // Quotient shifts in place; after 2W steps the old
                    // value is fully replaced.
                    q_reg <= {q_reg[2*W-2:0], q_bit};
                    dvd   <= {dvd[2*W-2:0], 1'b0};
                    if (cnt == '0) begin
                        state    <= S_DONE;
                        done_reg <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    busy_reg <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.q           = q_reg;
    assign bus.r           = r_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq (W=2) with a result scoreboard.
// Drives through divider_seq_if; compares on each done pulse.
module tb_divider_seq;
    localparam int W  = 2;
    localparam int DW = 2 * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    divider_seq_if #(.W(W)) dif ();

    divider_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [W-1:0]  b;
        logic [DW-1:0] q;
        logic [W-1:0]  r;
        logic          dbz;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t m;
        m.a = DW'(a);
        m.b = W'(b);
        if (b == 0) begin
            m.q   = '1;
            m.r   = '0;
            m.dbz = 1'b1;
        end else begin
            m.q   = DW'(a / b);
            m.r   = W'(a % b);
            m.dbz = 1'b0;
        end
        return m;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst === 1'b0 && dif.done === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("q", dif.q, e.q);
                chk("r", dif.r, e.r);
                chk("dbz", dif.div_by_zero, e.dbz);
                chk("busy_at_done", dif.busy, 1);
                if (e.b != 0) begin
                    chk("recon", 32'(e.b) * 32'(dif.q) + 32'(dif.r), e.a);
                    chk("r_lt_b", 32'(dif.r < e.b), 1);
                end
            end
        end
    end

    // Caller is 1 time unit after a rising edge, with the DUT idle.
    task automatic launch(input int a, input int b, input bit push);
        if (push) sb.push_back(model(a, b));
        dif.in1   = DW'(a);
        dif.in2   = W'(b);
        dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (dif.done !== 1'b1 && n < 40) begin
            chk("busy_calc", dif.busy, 1);
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", dif.done, 1);
    endtask

    task automatic to_idle();
        @(posedge clk); #1;
        chk("idle_busy", dif.busy, 0);
        chk("idle_done", dif.done, 0);
    endtask

    task automatic op(input int a, input int b);
        int n;
        launch(a, b, 1'b1);
        wait_done(n);
        chk("latency", n + 1, (b == 0) ? 1 : DW + 1);
        to_idle();
    endtask

    initial begin
        int n;
        dif.start = 1'b0;
        dif.in1   = '0;
        dif.in2   = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", dif.busy, 0);
        chk("rst_done", dif.done, 0);
        chk("rst_q", dif.q, 0);
        chk("rst_r", dif.r, 0);
        chk("rst_dbz", dif.div_by_zero, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        op(13, 3);
        chk("hold_q", dif.q, 4);
        chk("hold_r", dif.r, 1);

        // Start held through DONE is taken on the first IDLE cycle.
        launch(15, 3, 1'b1);
        wait_done(n);
        chk("latency_15_3", n + 1, DW + 1);
        sb.push_back(model(9, 2));
        dif.in1   = DW'(9);
        dif.in2   = W'(2);
        dif.start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_idle", dif.busy, 0);
        @(posedge clk); #1;
        chk("b2b_accept", dif.busy, 1);
        dif.start = 1'b0;
        wait_done(n);
        chk("latency_b2b", n + 1, DW + 1);
        to_idle();

        op(7, 0);
        chk("hold_dbz", dif.div_by_zero, 1);
        chk("hold_q_dbz", dif.q, 15);

        op(0, 1);

        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 4; b++)
                op(a, b);

        // New operands while calculating must not disturb the result.
        launch(13, 3, 1'b1);
        dif.in1   = DW'(15);
        dif.in2   = W'(1);
        dif.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        dif.start = 1'b0;
        wait_done(n);
        to_idle();

        // Reset in the second CALC cycle aborts the operation.
        launch(13, 3, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", dif.busy, 0);
        chk("abort_done", dif.done, 0);
        chk("abort_q", dif.q, 0);
        chk("abort_r", dif.r, 0);
        chk("abort_dbz", dif.div_by_zero, 0);
        repeat (8) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", dif.done, 0);
        end

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
